// File: rtl/apb_slave_regfile_if.sv
// APB link bundle between the requester (master) and the register-file completer (slave).
// Signals: psel/penable/pwrite/paddr/pwdata (master->slave), pready/prdata/pslverr (slave->master).
interface apb_slave_regfile_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic              pready;
    logic [DATA_W-1:0] prdata;
    logic              pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  pready, prdata, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output pready, prdata, pslverr
    );
endinterface

// File: rtl/apb_slave_regfile.sv
// APB completer register file with programmable wait states (WAIT_STATES access cycles).
// Ports: pclk, preset (async, active-high), apb (slave modport: psel/penable/pwrite/
// paddr/pwdata in, pready/prdata/pslverr out, all outputs registered).
// Macro APB_SLVERR_EN: paddr >= DEPTH completes with pslverr=1 and no access;
// when undefined, out-of-range addresses alias onto the low index bits.
module apb_slave_regfile #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int DEPTH       = 32,
    parameter int WAIT_STATES = 1
) (
    input logic                 pclk,
    input logic                 preset,
    apb_slave_regfile_if.slave  apb
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {IDLE, ACCESS} state_e;

    state_e            state_q;
    logic [3:0]        cnt_q;
    logic              pready_q;
    logic              pslverr_q;
    logic [DATA_W-1:0] prdata_q;
    logic              write_q;
    logic              err_q;
    logic [IDX_W-1:0]  idx_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] regs_q [DEPTH];

    logic [IDX_W-1:0]  idx_d;
    logic              err_d;
    logic [DATA_W-1:0] rdata_setup;
    logic [DATA_W-1:0] rdata_acc;
    logic              unused_paddr;

    assign idx_d = apb.paddr[IDX_W-1:0];
    // upper address bits only matter for the range check
    assign unused_paddr = ^apb.paddr;

`ifdef APB_SLVERR_EN
    assign err_d = {1'b0, apb.paddr} >= (ADDR_W + 1)'(DEPTH);
`else
    assign err_d = 1'b0;
`endif

    // setup-time read path is only used when WAIT_STATES == 0
    assign rdata_setup = (apb.pwrite || err_d) ? '0 : regs_q[idx_d];
    assign rdata_acc   = (write_q || err_q) ? '0 : regs_q[idx_q];

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
            write_q   <= 1'b0;
            err_q     <= 1'b0;
            idx_q     <= '0;
            wdata_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            unique case (state_q)
                IDLE: begin
                    pready_q  <= 1'b0;
                    pslverr_q <= 1'b0;
                    prdata_q  <= '0;
                    if (apb.psel && !apb.penable) begin
                        idx_q   <= idx_d;
                        write_q <= apb.pwrite;
                        wdata_q <= apb.pwdata;
                        err_q   <= err_d;
                        cnt_q   <= 4'(WAIT_STATES);
                        state_q <= ACCESS;
                        if (WAIT_STATES == 0) begin
                            pready_q  <= 1'b1;
                            pslverr_q <= err_d;
                            prdata_q  <= rdata_setup;
                        end
                    end
                end
                ACCESS: begin
                    if (!apb.psel) begin
                        // requester abort: drop the transfer
                        state_q   <= IDLE;
                        cnt_q     <= '0;
                        pready_q  <= 1'b0;
                        pslverr_q <= 1'b0;
                        prdata_q  <= '0;
                    end else if (apb.penable) begin
                        if (pready_q) begin
                            if (write_q && !err_q) begin
                                regs_q[idx_q] <= wdata_q;
                            end
                            state_q   <= IDLE;
                            pready_q  <= 1'b0;
                            pslverr_q <= 1'b0;
                            prdata_q  <= '0;
                        end else begin
                            cnt_q <= cnt_q - 4'd1;
                            if (cnt_q == 4'd1) begin
                                pready_q  <= 1'b1;
                                pslverr_q <= err_q;
                                prdata_q  <= rdata_acc;
                            end
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign apb.pready  = pready_q;
    assign apb.prdata  = prdata_q;
    assign apb.pslverr = pslverr_q;
endmodule
